// File: rtl/dcim_product_accumulator.sv
// dcim_product_accumulator: sums each frame of ADDR_COUNT products into a registered result with valid/ready handoff.
// Upstream cannot stall, so a completed frame that finds the output slot occupied is dropped and flagged.
module dcim_product_accumulator #(
    parameter int MULT_WIDTH = 16,
    parameter int ADDR_COUNT = 16,
    parameter int CNT_WIDTH  = 4,
    parameter int ACC_WIDTH  = MULT_WIDTH + CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MULT_WIDTH-1:0] prod_in,
    input  logic                  prod_valid,
    input  logic                  frame_clear,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic                  acc_valid,
    input  logic                  acc_ready,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic [7:0]            frame_count,
    output logic                  overrun
);
    logic [ACC_WIDTH-1:0] acc_q, acc_d, out_q, out_d, sum;
    logic [CNT_WIDTH-1:0] beat_q, beat_d;
    logic [7:0]           fcnt_q, fcnt_d;
    logic                 valid_q, valid_d, ovr_q, ovr_d;
    logic                 take, last, latch;

    always_comb begin
        sum     = acc_q + ACC_WIDTH'(prod_in);
        take    = prod_valid && !frame_clear;
        last    = take && beat_q == CNT_WIDTH'(ADDR_COUNT - 1);
        // a pending result being accepted on this edge frees the slot for the new one
        latch   = last && (!valid_q || acc_ready);
        acc_d   = (frame_clear || last) ? '0 : take ? sum : acc_q;
        beat_d  = (frame_clear || last) ? '0 : take ? beat_q + 1'b1 : beat_q;
        out_d   = latch ? sum : out_q;
        valid_d = latch || (valid_q && !acc_ready);
        fcnt_d  = fcnt_q + {7'd0, latch};
        ovr_d   = ovr_q || (last && !latch);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            beat_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            fcnt_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            fcnt_q  <= fcnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign acc_out     = out_q;
    assign acc_valid   = valid_q;
    assign beat_cnt    = beat_q;
    assign frame_count = fcnt_q;
    assign overrun     = ovr_q;
endmodule

// File: tb/tb_dcim_product_accumulator.sv
// tb_dcim_product_accumulator: directed test-plan sequences plus random traffic, scored against a frame-level model.
module tb_dcim_product_accumulator;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] prod_in = '0;
    logic        prod_valid = 1'b0;
    logic        frame_clear = 1'b0;
    logic        acc_ready = 1'b0;
    logic [19:0] acc_out;
    logic        acc_valid;
    logic [3:0]  beat_cnt;
    logic [7:0]  frame_count;
    logic        overrun;

    int checks = 0;
    int failures = 0;

    // reference model: products of the open frame, output-slot occupancy, counters
    int     frame[$];
    longint exp_q[$];
    bit     m_pending = 0;
    int     m_fc = 0;
    bit     m_ovr = 0;
    int     e_beat = 0, e_fc = 0;
    bit     e_ovr = 0, e_valid = 0;

    dcim_product_accumulator dut (
        .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
        .frame_clear(frame_clear), .acc_out(acc_out), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .beat_cnt(beat_cnt), .frame_count(frame_count),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // drive inputs for the next edge and advance the model to the state after that edge
    task automatic step(input bit pv, input logic [15:0] p, input bit fcl, input bit rdy);
        bit     accept;
        longint s;
        @(posedge clk);
        #1;
        prod_valid = pv; prod_in = p; frame_clear = fcl; acc_ready = rdy;
        e_beat = frame.size(); e_fc = m_fc; e_ovr = m_ovr; e_valid = m_pending;
        accept = m_pending && rdy;
        if (accept) m_pending = 0;
        if (fcl) frame.delete();
        else if (pv) begin
            frame.push_back(int'(p));
            if (frame.size() == N) begin
                s = 0;
                foreach (frame[i]) s += frame[i];
                frame.delete();
                if (!m_pending) begin
                    exp_q.push_back(s);
                    m_pending = 1;
                    m_fc = (m_fc + 1) % 256;
                end else m_ovr = 1;
            end
        end
    endtask

    task automatic idle(input bit rdy);
        step(0, 16'd0, 0, rdy);
    endtask

    task automatic frame_of(input logic [15:0] v, input bit rdy);
        for (int i = 0; i < N; i++) step(1, v, 0, rdy);
    endtask

    task automatic do_reset();
        #2;
        rst = 1; prod_valid = 0; frame_clear = 0; acc_ready = 0;
        #1;
        chk("rst_acc_out", acc_out, 0);
        chk("rst_acc_valid", acc_valid, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_overrun", overrun, 0);
        frame.delete(); exp_q.delete();
        m_pending = 0; m_fc = 0; m_ovr = 0;
        e_beat = 0; e_fc = 0; e_ovr = 0; e_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    // monitor: state tracking every cycle, result scoring on each handshake
    always @(negedge clk) begin
        if (!rst) begin
            chk("beat_cnt", beat_cnt, e_beat);
            chk("frame_count", frame_count, e_fc);
            chk("overrun", overrun, e_ovr);
            chk("acc_valid", acc_valid, e_valid);
            if (acc_valid && acc_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
                else chk("acc_out", acc_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        do_reset();
        // 1..16 with consumer ready
        for (int i = 1; i <= N; i++) step(1, 16'(i), 0, 1);
        idle(1);
        @(negedge clk);
        chk("t1_sum", acc_out, 136);
        chk("t1_valid", acc_valid, 1);
        chk("t1_fc", frame_count, 1);
        idle(1);
        @(negedge clk);
        chk("t1_valid_pulse", acc_valid, 0);
        // maximum-value frame, no wrap
        frame_of(16'hFFFF, 1);
        idle(1);
        @(negedge clk);
        chk("t2_max", acc_out, 20'hFFFF0);
        idle(1);
        // back-to-back frames with no consumer: second is dropped
        do_reset();
        frame_of(16'd2, 0);
        frame_of(16'd3, 0);
        idle(0);
        @(negedge clk);
        chk("t3_sum", acc_out, 32);
        chk("t3_valid", acc_valid, 1);
        chk("t3_ovr", overrun, 1);
        chk("t3_fc", frame_count, 1);
        idle(1);
        idle(0);
        @(negedge clk);
        chk("t3_drained", acc_valid, 0);
        chk("t3_hold", acc_out, 32);
        // accept on the exact completion edge of the next frame
        do_reset();
        frame_of(16'd1, 0);
        for (int i = 0; i < N - 1; i++) step(1, 16'd7, 0, 0);
        step(1, 16'd7, 0, 1);
        idle(0);
        @(negedge clk);
        chk("t4_sum", acc_out, 112);
        chk("t4_valid", acc_valid, 1);
        chk("t4_ovr", overrun, 0);
        chk("t4_fc", frame_count, 2);
        idle(1);
        // frame_clear beats a simultaneous product
        for (int i = 0; i < 7; i++) step(1, 16'($urandom), 0, 1);
        step(1, 16'd9, 1, 1);
        frame_of(16'd5, 1);
        idle(1);
        @(negedge clk);
        chk("t5_sum", acc_out, 80);
        chk("t5_beat", beat_cnt, 0);
        idle(1);
        // asynchronous reset mid-frame with a pending result
        frame_of(16'd6, 0);
        for (int i = 0; i < 5; i++) step(1, 16'd8, 0, 0);
        do_reset();
        frame_of(16'd4, 1);
        idle(1);
        @(negedge clk);
        chk("t6_sum", acc_out, 64);
        chk("t6_fc", frame_count, 1);
        idle(1);
        // random traffic with gaps, clears and a sporadic consumer
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 8, 16'($urandom), $urandom_range(0, 99) < 2,
                 $urandom_range(0, 9) < 3);
        repeat (3) idle(1);
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
